// File: rtl/mem_arb_pkg.sv
// Shared types and size encodings for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] SIZE_LOAD = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle; master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/arb_priority.sv
// Data-first winner select with a fetch starvation guard and streak update.
module arb_priority #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       req_if,
    input  logic       req_d,
    input  logic       pend_if,
    input  logic       hold_d,
    input  logic [3:0] streak,
    output logic       grant_if,
    output logic       grant_d,
    output logic [3:0] streak_nxt
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic force_if;

    // A data request held back only by its mask still outranks fetch, so
    // fetch cannot slip in between back-to-back data accesses unless forced.
    always_comb begin
        force_if   = pend_if && (streak == LIM);
        grant_if   = req_if && (force_if || (!req_d && !hold_d));
        grant_d    = req_d && !grant_if;
        streak_nxt = streak;
        if (grant_if)
            streak_nxt = '0;
        else if (grant_d)
            streak_nxt = !pend_if ? 4'd0 : ((streak == LIM) ? LIM : streak + 4'd1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional performance counters are enabled with MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_wready,
`ifdef MEM_ARB_PERF_EN
    input  logic [1:0]        perf_sel,
    output logic [31:0]       perf_data,
`endif
    mem_port_arbiter_if.master mem
);
    arb_state_t state;
    owner_t     owner;
    logic       drop, if_mask, d_mask;
    logic [3:0] streak, streak_nxt;
    logic       in_idle, eff_if, eff_d, pend_if, hold_d;
    logic       grant_if, grant_d, flush_hit, rd_done;

    assign in_idle   = (state == IDLE);
    assign pend_if   = if_req && !if_flush;
    assign eff_if    = in_idle && pend_if && !if_mask;
    assign eff_d     = in_idle && d_req && !d_mask;
    assign hold_d    = in_idle && d_req && d_mask;
    assign flush_hit = if_flush && (owner == OWN_IF) && !in_idle;
    assign rd_done   = mem.mem_rvalid &&
                       (((state == ISSUE) && mem.mem_gnt && !mem.mem_we) || (state == WAIT_RD));

    arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .req_if     (eff_if),
        .req_d      (eff_d),
        .pend_if    (pend_if),
        .hold_d     (hold_d),
        .streak     (streak),
        .grant_if   (grant_if),
        .grant_d    (grant_d),
        .streak_nxt (streak_nxt)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            drop          <= 1'b0;
            if_mask       <= 1'b0;
            d_mask        <= 1'b0;
            streak        <= '0;
            if_valid      <= 1'b0;
            if_rdata      <= '0;
            d_rvalid      <= 1'b0;
            d_rdata       <= '0;
            d_wready      <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_size  <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            d_rvalid <= 1'b0;
            d_wready <= 1'b0;
            if_mask  <= 1'b0;
            d_mask   <= 1'b0;
            streak   <= streak_nxt;
            if (flush_hit)
                drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_d) begin
                        mem.mem_addr  <= d_addr;
                        mem.mem_size  <= d_size;
                        mem.mem_wdata <= d_wdata;
                        mem.mem_we    <= (d_size != SIZE_LOAD);
                        mem.mem_req   <= 1'b1;
                        owner         <= OWN_D;
                        state         <= ISSUE;
                    end else if (grant_if) begin
                        mem.mem_addr  <= if_addr;
                        mem.mem_size  <= SIZE_LOAD;
                        mem.mem_we    <= 1'b0;
                        mem.mem_req   <= 1'b1;
                        owner         <= OWN_IF;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        if (mem.mem_we) begin
                            d_wready <= 1'b1;
                            d_mask   <= 1'b1;
                            state    <= IDLE;
                        end else if (mem.mem_rvalid) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: if (mem.mem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            // A flush arriving with the response itself still drops it.
            if (rd_done) begin
                drop <= 1'b0;
                if (owner == OWN_D) begin
                    d_rdata  <= mem.mem_rdata;
                    d_rvalid <= 1'b1;
                    d_mask   <= 1'b1;
                end else if (!(drop || flush_hit)) begin
                    if_rdata <= mem.mem_rdata;
                    if_valid <= 1'b1;
                    if_mask  <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_if_wait_cycles;
    logic        if_busy;

    assign if_busy = !in_idle && (owner == OWN_IF);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            perf_if_grants      <= '0;
            perf_d_grants       <= '0;
            perf_if_wait_cycles <= '0;
        end else begin
            if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_d)  perf_d_grants  <= perf_d_grants + 32'd1;
            if (pend_if && !grant_if && !if_busy)
                perf_if_wait_cycles <= perf_if_wait_cycles + 32'd1;
        end
    end

    always_comb begin
        perf_data = '0;
        case (perf_sel)
            2'b00:   perf_data = perf_if_grants;
            2'b01:   perf_data = perf_d_grants;
            2'b10:   perf_data = perf_if_wait_cycles;
            default: perf_data = '0;
        endcase
    end
`endif
endmodule
